// File: rtl/key_filter_multi.sv
// key_filter_multi: N-channel active-low key debouncer with press/release pulses.
// Long-press pulse output is enabled by defining KEY_FILTER_LONG_PRESS_EN.
module key_filter_multi #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LG_MAX = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LG_SAT = CNT_W'(LONG_CYCLES);
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
`endif
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < DEBOUNCE_CYCLES) begin : g_param_err
    $error("key_filter_multi: bad DEBOUNCE_CYCLES/LONG_CYCLES");
  end

  typedef enum logic [1:0] {
    UP, PRESS_FLT, DOWN, RELEASE_FLT
  } state_t;

  logic [N_KEYS-1:0] s1, s2;

  // Idle level is released (1) so reset never looks like a press.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

`ifndef KEY_FILTER_LONG_PRESS_EN
  assign key_long = '0;
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             prs_q, prs_d;
    logic             rel_q, rel_d;
`ifdef KEY_FILTER_LONG_PRESS_EN
    logic             lng_q, lng_d;
    logic             done_q, done_d;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        st_q   <= UP;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
`ifdef KEY_FILTER_LONG_PRESS_EN
        lng_q  <= 1'b0;
        done_q <= 1'b0;
`endif
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        prs_q  <= prs_d;
        rel_q  <= rel_d;
`ifdef KEY_FILTER_LONG_PRESS_EN
        lng_q  <= lng_d;
        done_q <= done_d;
`endif
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
`ifdef KEY_FILTER_LONG_PRESS_EN
      lng_d  = 1'b0;
      done_d = done_q;
`endif
      unique case (st_q)
        UP: begin
          if (!s2[i]) begin
            st_d  = PRESS_FLT;
            cnt_d = '0;
          end
        end
        PRESS_FLT: begin
          if (s2[i]) begin
            st_d  = UP;
            cnt_d = '0;
          end else if (cnt_q == DB_MAX) begin
            st_d  = DOWN;
            cnt_d = '0;
            lvl_d = 1'b1;
            prs_d = 1'b1;
`ifdef KEY_FILTER_LONG_PRESS_EN
            done_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        DOWN: begin
          if (s2[i]) begin
            st_d  = RELEASE_FLT;
            cnt_d = '0;
          end
`ifdef KEY_FILTER_LONG_PRESS_EN
          // done_q keeps a release bounce from re-arming the long pulse.
          else if (cnt_q == LG_MAX) begin
            cnt_d = LG_SAT;
            if (!done_q) begin
              lng_d  = 1'b1;
              done_d = 1'b1;
            end
          end else if (cnt_q != LG_SAT) begin
            cnt_d = cnt_q + ONE;
          end
`endif
        end
        RELEASE_FLT: begin
          if (!s2[i]) begin
            st_d  = DOWN;
            cnt_d = '0;
          end else if (cnt_q == DB_MAX) begin
            st_d  = UP;
            cnt_d = '0;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          st_d  = UP;
          cnt_d = '0;
        end
      endcase
    end

    assign key_state[i]   = lvl_q;
    assign key_press[i]   = prs_q;
    assign key_release[i] = rel_q;
`ifdef KEY_FILTER_LONG_PRESS_EN
    assign key_long[i]    = lng_q;
`endif
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: scoreboard bench for key_filter_multi (N=4, DB=16, LONG=64).
// Reference model counts consecutive opposing samples; events land 2 edges later.
module tb_key_filter_multi;
  localparam int N  = 4;
  localparam int DB = 16;
  localparam int LG = 64;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  always #5 Clk = ~Clk;

  key_filter_multi #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LG)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] st;
  } ev_t;

  ev_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [N-1:0] lvl;
  int rc[N];
  int hc[N];
  bit ldone[N];

  int press_cnt[N];
  int rel_cnt[N];
  int long_cnt[N];
  int last_press_cyc[N];
  int last_rel_cyc[N];
  int last_long_cyc[N];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic void model_flush();
    lvl = '0;
    for (int i = 0; i < N; i++) begin
      rc[i] = 0;
      hc[i] = 0;
      ldone[i] = 1'b0;
    end
    q.delete();
  endfunction

  // A level change is accepted on the (DB+1)th consecutive opposing sample.
  function automatic void model_edge(input logic [N-1:0] k);
    ev_t e;
    bit  p;
    e.cyc = cyc + 2;
    e.prs = '0;
    e.rel = '0;
    e.lng = '0;
    for (int i = 0; i < N; i++) begin
      p = !k[i];
      if (p != lvl[i]) begin
        rc[i]++;
      end else begin
        if (lvl[i]) begin
          if (rc[i] != 0) hc[i] = 0;
          else begin
            hc[i]++;
`ifdef KEY_FILTER_LONG_PRESS_EN
            if (hc[i] == LG && !ldone[i]) begin
              e.lng[i] = 1'b1;
              ldone[i] = 1'b1;
            end
`endif
          end
        end
        rc[i] = 0;
      end
      if (rc[i] == DB + 1) begin
        lvl[i] = p;
        rc[i] = 0;
        hc[i] = 0;
        if (p) begin
          e.prs[i] = 1'b1;
          ldone[i] = 1'b0;
        end else begin
          e.rel[i] = 1'b1;
        end
      end
    end
    e.st = lvl;
    if ((e.prs | e.rel | e.lng) != '0) q.push_back(e);
  endfunction

  task automatic step(input logic [N-1:0] nk);
    @(posedge Clk);
    cyc++;
    if (Reset_n) model_edge(key_in);
    #1 key_in = nk;
  endtask

  task automatic drive(input logic [N-1:0] v, input int n, output int tchg);
    step(v);
    tchg = cyc;
    repeat (n - 1) step(v);
  endtask

  initial begin
    ev_t e;
    bit  due;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i] = 0;
      long_cnt[i] = 0;
      last_press_cyc[i] = -1;
      last_rel_cyc[i] = -1;
      last_long_cyc[i] = -1;
    end
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL missed_event: got none expected event due at cycle %0d (now %0d)",
                   q[0].cyc, cyc);
          void'(q.pop_front());
        end
        due = (q.size() > 0) && (q[0].cyc == cyc);
        if ((key_press | key_release | key_long) != '0 || due) begin
          if (!due) begin
            chk("unexpected_event", int'({key_press, key_release, key_long}), 0);
          end else begin
            e = q.pop_front();
            chk("ev_press", int'(key_press), int'(e.prs));
            chk("ev_release", int'(key_release), int'(e.rel));
            chk("ev_long", int'(key_long), int'(e.lng));
            chk("ev_state", int'(key_state), int'(e.st));
          end
        end
        for (int i = 0; i < N; i++) begin
          if (key_press[i]) begin
            press_cnt[i]++;
            last_press_cyc[i] = cyc;
          end
          if (key_release[i]) begin
            rel_cnt[i]++;
            last_rel_cyc[i] = cyc;
          end
          if (key_long[i]) begin
            long_cnt[i]++;
            last_long_cyc[i] = cyc;
          end
        end
      end
    end
  end

  initial begin
    int t, tc, t2;
    int bp[N];
    int br[N];
    int bl[N];
    logic [N-1:0] kv;
    int mode;

    model_flush();
    Reset_n = 1'b0;
    key_in = '0;
    repeat (3) step('0);
    chk("rst_state", int'(key_state), 0);
    chk("rst_press", int'(key_press), 0);
    chk("rst_release", int'(key_release), 0);
    chk("rst_long", int'(key_long), 0);

    Reset_n = 1'b1;
    tc = cyc;
    repeat (30) step('0);
    chk("rst_held_press_cyc0", last_press_cyc[0], tc + 19);
    chk("rst_held_press_cyc3", last_press_cyc[3], tc + 19);
    chk("rst_held_press_cnt", press_cnt[1], 1);
    chk("rst_held_state", int'(key_state), 4'hF);

    drive(4'hF, 30, t);
    chk("all_release_state", int'(key_state), 0);

    for (int i = 0; i < N; i++) begin
      bp[i] = press_cnt[i];
      br[i] = rel_cnt[i];
      bl[i] = long_cnt[i];
    end
    drive(4'b1110, 40, tc);
    chk("clean_press_cyc", last_press_cyc[0], tc + 19);
    chk("clean_press_cnt", press_cnt[0] - bp[0], 1);
    chk("clean_other_keys", press_cnt[1] + press_cnt[2] + press_cnt[3]
        - bp[1] - bp[2] - bp[3], 0);
    chk("clean_no_release", rel_cnt[0] - br[0], 0);
    chk("clean_state", int'(key_state), 4'b0001);

    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 4, t);
      drive(4'b1110, 4, t);
    end
    drive(4'hF, 30, tc);
    chk("bounce_release_cyc", last_rel_cyc[0], tc + 19);
    chk("bounce_release_cnt", rel_cnt[0] - br[0], 1);
    chk("bounce_release_no_press", press_cnt[0] - bp[0], 1);
    chk("bounce_release_state", int'(key_state), 0);

    bp[0] = press_cnt[0];
    for (int k = 0; k < 10; k++) drive((k % 2 == 0) ? 4'b1110 : 4'b1111, 5, t);
    drive(4'b1110, 40, tc);
    chk("bounce_press_cyc", last_press_cyc[0], tc + 19);
    chk("bounce_press_cnt", press_cnt[0] - bp[0], 1);
    drive(4'hF, 30, t);

    bp[0] = press_cnt[0];
    for (int g = 1; g <= 15; g++) begin
      drive(4'b1110, g, t);
      drive(4'hF, 5, t);
    end
    chk("glitch_no_press", press_cnt[0] - bp[0], 0);

    drive(4'b0101, 5, tc);
    drive(4'b0001, 30, t2);
    chk("simul_press_k1", last_press_cyc[1], tc + 19);
    chk("simul_press_k3", last_press_cyc[3], tc + 19);
    chk("simul_press_k2", last_press_cyc[2], t2 + 19);
    chk("simul_state", int'(key_state), 4'b1110);
    drive(4'hF, 30, t);

    bl[2] = long_cnt[2];
    br[2] = rel_cnt[2];
    drive(4'b1011, 150, tc);
`ifdef KEY_FILTER_LONG_PRESS_EN
    chk("long_cyc", last_long_cyc[2], tc + 19 + LG);
    chk("long_cnt", long_cnt[2] - bl[2], 1);
`else
    chk("long_absent", long_cnt[2] - bl[2], 0);
`endif
    drive(4'hF, 30, t);
    chk("long_release", rel_cnt[2] - br[2], 1);

    drive(4'b1100, 10, t);
    drive(4'b1100, 30, t);
    Reset_n = 1'b0;
    model_flush();
    repeat (3) step(4'b1100);
    chk("midrst_state", int'(key_state), 0);
    chk("midrst_pulses", int'({key_press, key_release, key_long}), 0);
    Reset_n = 1'b1;
    tc = cyc;
    repeat (30) step(4'b1100);
    chk("midrst_repress", last_press_cyc[1], tc + 19);
    drive(4'hF, 30, t);

    kv = '1;
    for (int s = 0; s < 15; s++) begin
      mode = $urandom_range(0, 2);
      repeat (200) begin
        for (int i = 0; i < N; i++) begin
          if (mode == 0 && $urandom_range(0, 2) == 0) kv[i] = ~kv[i];
          if (mode == 1 && $urandom_range(0, 29) == 0) kv[i] = ~kv[i];
          if (mode == 2 && $urandom_range(0, 99) == 0) kv[i] = ~kv[i];
        end
        step(kv);
      end
    end

    drive(4'hF, 40, t);
    chk("queue_empty", q.size(), 0);
    chk("final_state", int'(key_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
